max_tree_pipe: RTL
==================

Name: max_tree_pipe

Overview:
- Parametrised, pipelined max/min reduction tree over CHANNELS IEEE-754 floating-point values.
- Returns the winning value and its channel index (argmax/argmin).
- Sits between the Q-value memory read port and the action-select / Q-update logic; replaces single-level combinational pairwise max blocks.
- Adds registered tree levels, valid/ready flow control, a per-transaction MAX/MIN mode, and index tracking.

Parameters:
- DATA_WIDTH, 32: width of one floating-point element (IEEE-754 single).
- CHANNELS, 4: number of input elements, >=1; any value, odd counts allowed at every level.
- IDX_WIDTH, (CHANNELS>1 ? $clog2(CHANNELS) : 1): width of the channel index output.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_data  input  DATA_WIDTH*CHANNELS  element k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- i_mode  input  1  0 = max, 1 = min; sampled with i_data.
- i_valid  input  1  input beat present.
- o_ready  output  1  block accepts a beat this cycle.
- o_data  output  DATA_WIDTH  winning value.
- o_index  output  IDX_WIDTH  channel number of winning value.
- o_valid  output  1  o_data/o_index valid.
- i_ready  input  1  downstream accepts the output this cycle.

Behaviour:
- Reset (rst=1 at clock edge):
  - All stage valid bits clear; o_valid=0, o_data=0, o_index=0.
  - o_ready=1 from the cycle after reset.
  - Reset mid-operation discards all in-flight beats; no output is produced for them.
- Structure:
  - LEVELS = max(1, ceil(log2(CHANNELS))) register stages.
  - Each level pairs adjacent entries (2j, 2j+1) into one entry. The number of entries at a level is ceil(previous/2).
  - An odd trailing entry passes through the level unchanged, with its index, and is still registered.
  - CHANNELS=1 gives one pass-through stage; o_index is always 0.
- Mode: i_mode travels with its beat through every stage. Beats with different modes may be interleaved back-to-back.
- Comparison:
  - Each element maps to an unsigned key. If the sign bit is 0: key = bits with the MSB set. If the sign bit is 1: key = ~bits.
  - Max picks the larger key; min picks the smaller key.
  - +0 and -0 compare as different keys (+0 > -0).
  - NaNs are not special-cased: they order by key (+NaN above +inf, -NaN below -inf).
- Ties: equal keys select the lower-index operand, so the result is always the lowest channel index holding the winning value.
- Flow control:
  - advance = ~o_valid | i_ready; o_ready = advance.
  - When advance=1, all stages shift one level; stage 0 loads the i_data/i_mode/i_valid beat.
  - When advance=0, all stages hold, including bubbles (global stall; no bubble compression).
  - A beat is accepted when i_valid & o_ready. o_data/o_index stay stable while o_valid & ~i_ready.
- Latency and throughput:
  - An accepted beat appears at the output exactly LEVELS cycles later if no stall occurs.
  - Throughput is 1 beat/cycle with i_ready held high.
  - Beats emerge in acceptance order.
- Simultaneous i_valid and output stall: o_ready=0, and the input beat is not taken. The source must hold i_data until o_ready=1.
- Outputs come from registers only; there is no combinational path from i_data to o_data. o_ready depends combinationally on o_valid and i_ready.

Test Plan:
- CHANNELS=4, max:
  - i_data = {k3=0x40000000 (2.0), k2=0x3F800000 (1.0), k1=0xC0400000 (-3.0), k0=0x3F000000 (0.5)}.
  - Required: o_data=0x40000000, o_index=2'd3, o_valid=1 exactly 2 cycles after acceptance.
- Same data, i_mode=1 (min) -> o_data=0xC0400000, o_index=1.
- Ties:
  - All four inputs = 0x3F800000 with max -> o_index=0.
  - {+0=0x00000000 at k1, -0=0x80000000 at k0} in a 2-channel build with min -> o_index=0.
- CHANNELS=5, max:
  - Inputs 0.5, 1.0, -3.0, 2.0, 4.0 (0x40800000) on k0..k4.
  - Required: o_data=0x40800000, o_index=4, latency 3 cycles (odd pass-through verified).
- Back-pressure, CHANNELS=4:
  - Stream 6 beats back-to-back with alternating i_mode; hold i_ready=0 for 3 cycles mid-stream.
  - Required: o_data/o_index stable during the stall and o_ready=0 while o_valid & ~i_ready. All 6 results arrive in order with correct values; none dropped or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> o_valid=0 the next cycle, no stale outputs afterwards, and the next accepted beat is correct after 2 cycles.

Source files
------------

// File: rtl/max_tree_pipe.sv
// max_tree_pipe: pipelined argmax/argmin reduction over CHANNELS IEEE-754 values.
// One register stage per tree level. A global stall holds every stage, bubbles included.
module max_tree_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned IDX_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
  input  logic                           i_mode,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [IDX_WIDTH-1:0]           o_index,
  output logic                           o_valid,
  input  logic                           i_ready
);

  localparam int unsigned LEVELS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Number of entries present at the input of level lvl (lvl == LEVELS gives the root).
  function automatic int unsigned f_cnt(input int unsigned lvl);
    int unsigned n;
    n = CHANNELS;
    for (int unsigned i = 0; i < lvl; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  // Offset of the output entries of level lvl inside the flattened stage storage.
  function automatic int unsigned f_off(input int unsigned lvl);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < lvl; i++) begin
      s = s + f_cnt(i + 1);
    end
    return s;
  endfunction

  // Order-preserving unsigned key: positives above negatives, +0 above -0.
  function automatic logic [DATA_WIDTH-1:0] f_key(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] k;
    if (x[DATA_WIDTH-1]) begin
      k = ~x;
    end else begin
      k = {1'b1, x[DATA_WIDTH-2:0]};
    end
    return k;
  endfunction

  localparam int unsigned TOTAL = f_off(LEVELS);
  localparam int unsigned LAST  = f_off(LEVELS - 1);

  logic [DATA_WIDTH-1:0] r_data     [TOTAL];
  logic [IDX_WIDTH-1:0]  r_idx      [TOTAL];
  logic [DATA_WIDTH-1:0] w_nxt_data [TOTAL];
  logic [IDX_WIDTH-1:0]  w_nxt_idx  [TOTAL];
  logic [LEVELS-1:0]     r_valid;
  logic [LEVELS-1:0]     w_nxt_valid;
  logic [LEVELS-1:0]     w_lvl_mode;
  logic                  w_advance;

  // Whole pipe moves together whenever the output slot is empty or being drained.
  assign w_advance = ~r_valid[LEVELS-1] | i_ready;

  assign w_nxt_valid[0] = i_valid;
  assign w_lvl_mode[0]  = i_mode;

  if (LEVELS > 1) begin : g_mode
    logic [LEVELS-2:0] r_mode;

    assign w_nxt_valid[LEVELS-1:1] = r_valid[LEVELS-2:0];
    assign w_lvl_mode[LEVELS-1:1]  = r_mode;

    // Mode rides with its beat; the root stage no longer needs it.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_mode <= '0;
      end else if (w_advance) begin
        r_mode <= w_lvl_mode[LEVELS-2:0];
      end
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned NIN  = f_cnt(l);
    localparam int unsigned NOUT = f_cnt(l + 1);
    localparam int unsigned OOUT = f_off(l);

    logic [DATA_WIDTH-1:0] w_in_data [NIN];
    logic [IDX_WIDTH-1:0]  w_in_idx  [NIN];

    for (genvar k = 0; k < NIN; k++) begin : g_src
      if (l == 0) begin : g_port
        assign w_in_data[k] = i_data[DATA_WIDTH*k +: DATA_WIDTH];
        assign w_in_idx[k]  = IDX_WIDTH'(k);
      end else begin : g_reg
        assign w_in_data[k] = r_data[f_off(l - 1) + k];
        assign w_in_idx[k]  = r_idx[f_off(l - 1) + k];
      end
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_node
      if (2 * j + 1 < NIN) begin : g_cmp
        logic [DATA_WIDTH-1:0] w_key_a;
        logic [DATA_WIDTH-1:0] w_key_b;
        logic                  w_take_b;

        assign w_key_a = f_key(w_in_data[2*j]);
        assign w_key_b = f_key(w_in_data[2*j+1]);
        // Strict compare: on a tie the lower-index operand (a) wins.
        assign w_take_b = w_lvl_mode[l] ? (w_key_b < w_key_a) : (w_key_b > w_key_a);
        assign w_nxt_data[OOUT + j] = w_take_b ? w_in_data[2*j+1] : w_in_data[2*j];
        assign w_nxt_idx[OOUT + j]  = w_take_b ? w_in_idx[2*j+1]  : w_in_idx[2*j];
      end else begin : g_pass
        // Odd trailing entry is carried through this level untouched.
        assign w_nxt_data[OOUT + j] = w_in_data[2*j];
        assign w_nxt_idx[OOUT + j]  = w_in_idx[2*j];
      end
    end
  end

  // Stage registers for all levels; reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < TOTAL; i++) begin
        r_data[i] <= '0;
        r_idx[i]  <= '0;
      end
    end else if (w_advance) begin
      r_valid <= w_nxt_valid;
      for (int unsigned i = 0; i < TOTAL; i++) begin
        r_data[i] <= w_nxt_data[i];
        r_idx[i]  <= w_nxt_idx[i];
      end
    end
  end

  assign o_ready = w_advance;
  assign o_valid = r_valid[LEVELS-1];
  assign o_data  = r_data[LAST];
  assign o_index = r_idx[LAST];

endmodule
